seq_det_ctrl: RTL and testbench
===============================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits (legal range 2..16).
REQ-002 Parameter CNT_W, default 8: width of the match counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL provide the following ports:
- clk  input  1  clock, all state on the rising edge.
- rst  input  1  asynchronous active-low reset.
- cfg_valid  input  1  configuration request.
- cfg_ready  output  1  configuration accepted this cycle when high with cfg_valid.
- cfg_pattern  input  MAX_LEN  pattern; bit cfg_len-1 is the first bit received.
- cfg_len  input  5  pattern length, legal 1..MAX_LEN.
- arm  input  1  start detection.
- disarm  input  1  stop detection.
- in  input  1  serial data bit.
- in_valid  input  1  in is sampled this cycle.
- out  output  1  match pulse.
- match_cnt  output  CNT_W  matches since last arm, saturating.
- busy  output  1  high in ARMED.
- cfg_err  output  1  one-cycle error pulse.

Function
REQ-005 The FSM SHALL have two states, IDLE and ARMED; busy SHALL equal (state==ARMED).
REQ-006 cfg_ready SHALL be high only in IDLE; a transfer occurs on an edge where cfg_valid && cfg_ready.
REQ-007 On a transfer with cfg_len in 1..MAX_LEN, the block SHALL latch pattern and length and set the internal cfg_ok flag.
REQ-008 On a transfer with cfg_len of 0 or greater than MAX_LEN, the block SHALL pulse cfg_err for one cycle and leave the stored configuration and cfg_ok unchanged.
REQ-009 arm in IDLE with cfg_ok=1 SHALL move the FSM to ARMED on the next edge, clearing the history register, the fill count and match_cnt.
REQ-010 arm in IDLE with cfg_ok=0 SHALL pulse cfg_err and keep the FSM in IDLE.
REQ-011 disarm in ARMED SHALL return the FSM to IDLE on the next edge; match_cnt SHALL hold its value.
REQ-012 When arm and disarm are asserted together, disarm SHALL win; arm in ARMED is ignored.
REQ-013 In ARMED with in_valid=1 and disarm=0, the history register SHALL shift as hist <= {hist[MAX_LEN-2:0], in}.
REQ-014 In ARMED with in_valid=1 and disarm=0, the fill count SHALL increment, saturating at MAX_LEN.
REQ-015 A match SHALL occur on a shifting edge when the low cfg_len bits of the new history equal cfg_pattern[cfg_len-1:0] and the new fill count is at least cfg_len.
REQ-016 out SHALL be registered and high for exactly the one cycle following the matching edge, which gives one cycle of latency from sampling the last bit.
REQ-017 On each match, match_cnt SHALL increment, saturating at 2^CNT_W-1.
REQ-018 In-valid bits presented in IDLE, or on a cycle with disarm, SHALL be ignored.
REQ-019 cfg_valid presented in ARMED SHALL NOT be accepted (cfg_ready=0), and the stored configuration SHALL be unchanged.

Reset
REQ-020 rst=0 SHALL immediately force the following: state IDLE; cfg_ok=0; hist=0; fill=0; out=0; match_cnt=0; cfg_err=0; busy=0; cfg_ready=1 after release.
REQ-021 Reset asserted mid-detection SHALL discard the partial history; no out pulse SHALL follow reset release.

Configuration
REQ-022 With SEQ_DET_OVERLAP_EN defined, detection SHALL be overlapping: history and fill are kept after a match.
REQ-023 Without SEQ_DET_OVERLAP_EN, the fill count SHALL clear to 0 on each match, so that matches never share bits.

Verification
REQ-024 Overlap: with cfg 0110/len 4 (SEQ_DET_OVERLAP_EN defined), arm, then stream 0,1,1,0,1,1,0 -> out pulses after bits 4 and 7, and match_cnt=2.
REQ-025 Non-overlap: with the same cfg and stream as REQ-024 and the macro undefined -> out pulses after bit 4 only, and match_cnt=1.
REQ-026 Config errors:
- cfg_len=0 -> cfg_err pulse.
- A following arm with no prior valid cfg -> cfg_err pulse, busy stays 0.
REQ-027 Gaps: a stream of 0,1,1,0 with in_valid low for 3 cycles between each bit -> exactly one out pulse, one cycle after the fourth valid bit.
REQ-028 Saturation/control:
- CNT_W=2 with 5 matches -> match_cnt=3.
- arm and disarm asserted together in ARMED -> IDLE, with match_cnt held.
- cfg_valid in ARMED -> cfg_ready=0.
REQ-029 Reset mid-stream: after 3 bits of 0110, assert rst, re-arm, then send 0 -> no out pulse.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector: IDLE/ARMED control with a configurable pattern, a match pulse and a saturating match counter.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; by default matches never share bits.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [4:0]         cfg_len,
    input  logic               arm,
    input  logic               disarm,
    input  logic               in,
    input  logic               in_valid,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               busy,
    output logic               cfg_err
);

    localparam int FILL_W = 5;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);
    localparam logic [FILL_W-1:0] FILL_ONE = {{(FILL_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nx;
    logic [MAX_LEN-1:0]  pattern_r;
    logic [4:0]          len_r;
    logic                cfg_ok_r;
    logic [MAX_LEN-1:0]  hist_r;
    logic [MAX_LEN-1:0]  hist_nx;
    logic [FILL_W-1:0]   fill_r;
    logic [FILL_W-1:0]   fill_nx;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nx;
    logic                out_r;
    logic                cfg_err_r;
    logic                busy_r;
    logic                cfg_ready_r;
    logic                cfg_xfer_s;
    logic                cfg_len_ok_s;
    logic                match_s;
    logic                err_nx;
    logic [MAX_LEN-1:0]  mask_s;

    // Mask covering the low len bits; len == MAX_LEN wraps to all ones.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [4:0] len);
        logic [MAX_LEN:0] one_hot;
        one_hot = {{MAX_LEN{1'b0}}, 1'b1} << len;
        return one_hot[MAX_LEN-1:0] - {{(MAX_LEN-1){1'b0}}, 1'b1};
    endfunction

    assign cfg_len_ok_s = (cfg_len != 5'd0) && (cfg_len <= 5'(MAX_LEN));
    assign mask_s       = len_mask(len_r);

    // Next-state, history/fill/counter update and error request.
    always_comb begin
        state_nx   = state_r;
        hist_nx    = hist_r;
        fill_nx    = fill_r;
        cnt_nx     = cnt_r;
        match_s    = 1'b0;
        err_nx     = 1'b0;
        cfg_xfer_s = 1'b0;
        case (state_r)
            IDLE: begin
                cfg_xfer_s = cfg_valid;
                err_nx     = cfg_valid && !cfg_len_ok_s;
                if (arm && !disarm) begin
                    if (cfg_ok_r) begin
                        state_nx = ARMED;
                        hist_nx  = {MAX_LEN{1'b0}};
                        fill_nx  = {FILL_W{1'b0}};
                        cnt_nx   = {CNT_W{1'b0}};
                    end else begin
                        err_nx = 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            ARMED: begin
                if (disarm) begin
                    state_nx = IDLE;
                end else if (in_valid) begin
                    hist_nx = {hist_r[MAX_LEN-2:0], in};
                    fill_nx = (fill_r < FILL_MAX) ? fill_r + FILL_ONE : fill_r;
                    match_s = ((hist_nx & mask_s) == (pattern_r & mask_s)) && (fill_nx >= len_r);
                    if (match_s) begin
                        cnt_nx = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
                        // Without overlap the next match must be built from fresh bits only.
                        if (!OVERLAP) begin
                            fill_nx = {FILL_W{1'b0}};
                        end else begin
                            fill_nx = fill_nx;
                        end
                    end else begin
                        cnt_nx = cnt_r;
                    end
                end else begin
                    state_nx = ARMED;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            pattern_r   <= {MAX_LEN{1'b0}};
            len_r       <= 5'd0;
            cfg_ok_r    <= 1'b0;
            hist_r      <= {MAX_LEN{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            out_r       <= 1'b0;
            cfg_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
        end else begin
            state_r     <= state_nx;
            hist_r      <= hist_nx;
            fill_r      <= fill_nx;
            cnt_r       <= cnt_nx;
            out_r       <= match_s;
            cfg_err_r   <= err_nx;
            busy_r      <= (state_nx == ARMED);
            cfg_ready_r <= (state_nx == IDLE);
            if (cfg_xfer_s && cfg_len_ok_s) begin
                pattern_r <= cfg_pattern;
                len_r     <= cfg_len;
                cfg_ok_r  <= 1'b1;
            end
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign busy      = busy_r;
    assign out       = out_r;
    assign match_cnt = cnt_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed testbench for seq_det_ctrl (MAX_LEN=8, CNT_W=2); expectations follow SEQ_DET_OVERLAP_EN.
module tb_seq_det_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [4:0]         cfg_len;
    logic               arm;
    logic               disarm;
    logic               in;
    logic               in_valid;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;
    logic               cfg_err;

    int checks = 0;
    int errors = 0;

    seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .arm(arm), .disarm(disarm),
        .in(in), .in_valid(in_valid), .out(out), .match_cnt(match_cnt),
        .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        in       = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic configure(input logic [7:0] p, input logic [4:0] l);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_disarm();
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
    endtask

    initial begin
        logic [6:0] stream;
        logic [3:0] gap_bits;
        logic [7:0] long_pat;
        logic [1:0] exp_cnt;

        rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = 8'h00; cfg_len = 5'd0;
        arm = 1'b0; disarm = 1'b0; in = 1'b0; in_valid = 1'b0;
        #3;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out", 32'(out), 32'd0);
        check_eq("rst_cnt", 32'(match_cnt), 32'd0);
        check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
        #9;
        rst = 1'b1;
        tick();
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);

        // Bad lengths, then arm with no valid configuration.
        configure(8'h06, 5'd0);
        check_eq("len0_err", 32'(cfg_err), 32'd1);
        tick();
        check_eq("len0_err_clr", 32'(cfg_err), 32'd0);
        do_arm();
        check_eq("arm_nocfg_err", 32'(cfg_err), 32'd1);
        check_eq("arm_nocfg_busy", 32'(busy), 32'd0);
        tick();
        check_eq("arm_nocfg_idle", 32'(busy), 32'd0);
        configure(8'h06, 5'd9);
        check_eq("len9_err", 32'(cfg_err), 32'd1);
        do_arm();
        check_eq("len9_arm_err", 32'(cfg_err), 32'd1);
        check_eq("len9_arm_busy", 32'(busy), 32'd0);

        // Pattern 0110 over 0,1,1,0,1,1,0.
        configure(8'h06, 5'd4);
        check_eq("cfg_ok_no_err", 32'(cfg_err), 32'd0);
        do_arm();
        check_eq("armed_busy", 32'(busy), 32'd1);
        check_eq("armed_ready", 32'(cfg_ready), 32'd0);
        check_eq("armed_cnt", 32'(match_cnt), 32'd0);
        stream = 7'b0110110;
        for (int i = 0; i < 7; i++) begin
            send_bit(stream[6-i]);
            check_eq($sformatf("ovl_out_%0d", i + 1), 32'(out),
                     32'((i == 3) || (OVL && (i == 6))));
        end
        exp_cnt = OVL ? 2'd2 : 2'd1;
        check_eq("ovl_cnt", 32'(match_cnt), 32'(exp_cnt));
        tick();
        check_eq("ovl_out_idle", 32'(out), 32'd0);

        // Config attempt while armed must be refused.
        cfg_pattern = 8'h03; cfg_len = 5'd2; cfg_valid = 1'b1;
        check_eq("armed_cfg_ready", 32'(cfg_ready), 32'd0);
        tick();
        cfg_valid = 1'b0;

        // arm together with disarm: disarm wins, counter held.
        arm = 1'b1; disarm = 1'b1;
        tick();
        arm = 1'b0; disarm = 1'b0;
        check_eq("armdis_busy", 32'(busy), 32'd0);
        check_eq("armdis_cnt", 32'(match_cnt), 32'(exp_cnt));

        // Gapped stream; old 0110/len4 config must still be in force.
        do_arm();
        check_eq("gap_cnt_clr", 32'(match_cnt), 32'd0);
        gap_bits = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            send_bit(gap_bits[3-i]);
            check_eq($sformatf("gap_out_b%0d", i + 1), 32'(out), 32'(i == 3));
            for (int g = 0; g < 3; g++) begin
                tick();
                check_eq($sformatf("gap_out_b%0d_g%0d", i + 1, g), 32'(out), 32'd0);
            end
        end
        check_eq("gap_cnt", 32'(match_cnt), 32'd1);

        // Disarm holds counter; bits in IDLE are ignored.
        do_disarm();
        check_eq("dis_busy", 32'(busy), 32'd0);
        check_eq("dis_cnt", 32'(match_cnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_bit(gap_bits[3-i]);
            check_eq($sformatf("idle_out_%0d", i + 1), 32'(out), 32'd0);
        end
        check_eq("idle_cnt", 32'(match_cnt), 32'd1);

        // Reset in the middle of a stream.
        do_arm();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_cnt", 32'(match_cnt), 32'd0);
        check_eq("midrst_ready", 32'(cfg_ready), 32'd1);
        #2;
        rst = 1'b1;
        do_arm();
        check_eq("midrst_nocfg_err", 32'(cfg_err), 32'd1);
        configure(8'h06, 5'd4);
        do_arm();
        check_eq("midrst_rearm", 32'(busy), 32'd1);
        send_bit(1'b0);
        check_eq("midrst_out", 32'(out), 32'd0);
        tick();
        check_eq("midrst_out2", 32'(out), 32'd0);

        // Full-length pattern: 10100110, first bit is the MSB.
        do_disarm();
        long_pat = 8'hA6;
        configure(long_pat, 5'd8);
        do_arm();
        for (int i = 0; i < 8; i++) begin
            send_bit(long_pat[7-i]);
            check_eq($sformatf("len8_out_%0d", i + 1), 32'(out), 32'(i == 7));
        end
        check_eq("len8_cnt", 32'(match_cnt), 32'd1);

        // Counter saturation with a 1-bit pattern.
        do_disarm();
        configure(8'h01, 5'd1);
        do_arm();
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
            check_eq($sformatf("sat_out_%0d", i + 1), 32'(out), 32'd1);
            check_eq($sformatf("sat_cnt_%0d", i + 1), 32'(match_cnt), 32'((i < 3) ? i + 1 : 3));
        end
        send_bit(1'b0);
        check_eq("sat_out_zero", 32'(out), 32'd0);
        check_eq("sat_cnt_hold", 32'(match_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
